// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, FSM encodings and the shared combinational
// round units (SubBytes, ShiftRows, MixColumns, AddRoundKey, S-box, xtime).
// Byte i of a 128-bit block lives in bits [8*i +: 8] of a [0:127] vector,
// column-major, so byte index = 4*column + row.
package aes_pkg;
  localparam int         NR        = 10;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1b;

  // Forward S-box, entry 0 in bits [0:7]
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row w of column c takes the byte from column (c + w) mod 4
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(4*c+w) +: 8] = s[8*(4*((c+w)%4)+w) +: 8];
    return r;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      r[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [0:127] add_round_key(input logic [0:127] s, input logic [0:127] k);
    return s ^ k;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, K_r = f(K_{r-1}, rcon).
// Purely combinational; four S-box lookups on RotWord(w3).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [0:127] key_in,
  input  logic [7:0]   rcon,
  output logic [0:127] key_out
);
  logic [0:31] w0, w1, w2, w3, sub_rot, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;
  assign sub_rot = {sbox(w3[8:15]), sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])};
  assign n0 = w0 ^ sub_rot ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one round per clock,
// round keys generated on the fly. Valid/ready on input and output.
// Optional feature: define AES_SEQ_ABORT_EN to add the 'abort' input, which
// drops an in-flight or completed block back to IDLE.
//
//   state | meaning
//   IDLE  | waiting for a plaintext/key pair
//   RUN   | applying rounds 1..NR, one per clock
//   DONE  | ciphertext held on out_text until out_ready
module aes128_round_sequencer #(
  parameter int NR    = aes_pkg::NR,
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef AES_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_text,
  input  logic [0:127]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_text,
  output logic             busy,
  output logic [RND_W-1:0] round
);
  import aes_pkg::*;

  logic [1:0]   fsm;
  logic [0:127] state_reg, key_reg, round_key;
  logic [0:127] mc_in, mc_out, ark_in;
  logic [7:0]   rcon;
  logic         abort_req, abort_hit, accept, last_round;

`ifdef AES_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Abort only means something once a block is in flight or waiting
  assign abort_hit  = abort_req && (fsm != IDLE);
  // Readiness in DONE lets a new block start on the same edge the old one leaves
  assign in_ready   = (fsm == IDLE) || ((fsm == DONE) && out_ready && !abort_req);
  assign accept     = in_valid && in_ready;
  assign last_round = (round == RND_W'(NR));
  assign busy       = (fsm == RUN);
  assign out_text   = state_reg;

  aes_key_step u_key_step (
    .key_in  (key_reg),
    .rcon    (rcon),
    .key_out (round_key)
  );

  assign mc_in  = shift_rows(sub_bytes(state_reg));
  assign mc_out = mix_columns(mc_in);
  // The final round skips MixColumns
  assign ark_in = last_round ? mc_in : mc_out;

  // Sequencer state, round datapath registers and handshake flags
  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      fsm       <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rcon      <= '0;
      round     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      fsm       <= RUN;
      state_reg <= add_round_key(in_text, in_key);
      key_reg   <= in_key;
      rcon      <= RCON_INIT;
      round     <= RND_W'(1);
      out_valid <= 1'b0;
    end else if (fsm == RUN) begin
      state_reg <= add_round_key(ark_in, round_key);
      key_reg   <= round_key;
      rcon      <= xtime(rcon);
      if (last_round) begin
        fsm       <= DONE;
        out_valid <= 1'b1;
      end else begin
        round <= round + RND_W'(1);
      end
    end else if ((fsm == DONE) && out_ready) begin
      fsm       <= IDLE;
      out_valid <= 1'b0;
      round     <= '0;
    end
  end
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for aes128_round_sequencer. Expected ciphertexts come
// from FIPS-197 constants and from a byte-array AES model with a full key
// expansion and an S-box computed from GF(2^8) inversion.
module tb_aes128_round_sequencer;
  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127] in_text, in_key, out_text;
  logic [3:0]   round;
`ifdef AES_SEQ_ABORT_EN
  logic         abort;
`endif
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   sbt [256];

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_SR1 = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [0:127] C1_MC1 = 128'h5f72641557f5bc92f7be3b291db9f91a;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes128_round_sequencer dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_text   (in_text),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .busy      (busy),
    .round     (round)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int v = 0; v < 256; v++) begin
      b   = v[7:0];
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, b);
      end
      sbt[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] aes_ref(input logic [0:127] key, input logic [0:127] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc;
    logic [0:127] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[8*i +: 8];
      s[i] = pt[8*i +: 8] ^ w[i];
    end
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp[0] = sbt[w[4*(i-1)+1]] ^ rc;
        tmp[1] = sbt[w[4*(i-1)+2]];
        tmp[2] = sbt[w[4*(i-1)+3]];
        tmp[3] = sbt[w[4*(i-1)]];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          t[0] = gmul(8'h02, s[4*c]) ^ gmul(8'h03, s[4*c+1]) ^ s[4*c+2] ^ s[4*c+3];
          t[1] = s[4*c] ^ gmul(8'h02, s[4*c+1]) ^ gmul(8'h03, s[4*c+2]) ^ s[4*c+3];
          t[2] = s[4*c] ^ s[4*c+1] ^ gmul(8'h02, s[4*c+2]) ^ gmul(8'h03, s[4*c+3]);
          t[3] = gmul(8'h03, s[4*c]) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(8'h02, s[4*c+3]);
          for (int row = 0; row < 4; row++) s[4*c+row] = t[row];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait (bounded) for in_ready, then scramble the inputs
  task automatic send(input logic [0:127] key, input logic [0:127] pt);
    int guard;
    guard    = 0;
    in_key   = key;
    in_text  = pt;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    in_key   = rand128();
    in_text  = rand128();
  endtask

  // Edges from now until out_valid is seen; -1 if it never comes
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if ({in_ready, busy, out_valid, round} !== 7'b100_0000) begin n_err++; $display("FAIL reset_flags got=%b want=%b", {in_ready, busy, out_valid, round}, 7'b100_0000); end
    n_cmp++; if (out_text !== 128'h0) begin n_err++; $display("FAIL reset_out_text got=%h want=0", out_text); end
  endtask

  task automatic test_fips_c1();
    logic [0:127] exp;
    exp = aes_ref(C1_KEY, C1_PT);
    send(C1_KEY, C1_PT);
    n_cmp++; if (dut.mc_in !== C1_SR1) begin n_err++; $display("FAIL c1_round1_mc_in got=%h want=%h", dut.mc_in, C1_SR1); end
    n_cmp++; if (dut.mc_out !== C1_MC1) begin n_err++; $display("FAIL c1_round1_mc_out got=%h want=%h", dut.mc_out, C1_MC1); end
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if ({busy, out_valid, round} !== {2'b10, 4'(k + 1)}) begin n_err++; $display("FAIL c1_run_edge%0d got=%b want=%b", k, {busy, out_valid, round}, {2'b10, 4'(k + 1)}); end
      tick();
    end
    n_cmp++; if ({busy, out_valid, round} !== 6'b01_1010) begin n_err++; $display("FAIL c1_done_flags got=%b want=%b", {busy, out_valid, round}, 6'b01_1010); end
    n_cmp++; if (out_text !== C1_CT) begin n_err++; $display("FAIL c1_ciphertext got=%h want=%h", out_text, C1_CT); end
    n_cmp++; if (out_text !== exp) begin n_err++; $display("FAIL c1_vs_model got=%h want=%h", out_text, exp); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if ({in_ready, busy, out_valid, round} !== 7'b100_0000) begin n_err++; $display("FAIL c1_drain_idle got=%b want=%b", {in_ready, busy, out_valid, round}, 7'b100_0000); end
  endtask

  task automatic test_fips_b_hold();
    int n;
    send(B_KEY, B_PT);
    wait_valid(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL b_latency got=%0d want=10", n); end
    for (int h = 0; h < 5; h++) begin
      n_cmp++; if ({out_valid, in_ready, out_text} !== {2'b10, B_CT}) begin n_err++; $display("FAIL b_hold%0d got=%b/%b/%h want=1/0/%h", h, out_valid, in_ready, out_text, B_CT); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if ({in_ready, out_valid, round} !== 6'b10_0000) begin n_err++; $display("FAIL b_drain got=%b want=%b", {in_ready, out_valid, round}, 6'b10_0000); end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_key    = C1_KEY;
    in_text   = C1_PT;
    tick();
    in_key  = B_KEY;
    in_text = B_PT;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL b2b_first_latency got=%0d want=10", n); end
    n_cmp++; if (out_text !== C1_CT) begin n_err++; $display("FAIL b2b_first_ct got=%h want=%h", out_text, C1_CT); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_in_done got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    in_key   = rand128();
    in_text  = rand128();
    n_cmp++; if ({busy, out_valid, round} !== 6'b10_0001) begin n_err++; $display("FAIL b2b_no_gap got=%b want=%b", {busy, out_valid, round}, 6'b10_0001); end
    wait_valid(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL b2b_second_latency got=%0d want=10", n); end
    n_cmp++; if (out_text !== B_CT) begin n_err++; $display("FAIL b2b_second_ct got=%h want=%h", out_text, B_CT); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if ({in_ready, out_valid, round} !== 6'b10_0000) begin n_err++; $display("FAIL b2b_drain got=%b want=%b", {in_ready, out_valid, round}, 6'b10_0000); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    send(C1_KEY, C1_PT);
    repeat (4) tick();
    n_cmp++; if (round !== 4'd5) begin n_err++; $display("FAIL rst_mid_round got=%0d want=5", round); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({in_ready, busy, out_valid, round} !== 7'b100_0000) begin n_err++; $display("FAIL rst_mid_flags got=%b want=%b", {in_ready, busy, out_valid, round}, 7'b100_0000); end
    n_cmp++; if (out_text !== 128'h0) begin n_err++; $display("FAIL rst_mid_out_text got=%h want=0", out_text); end
    n = 0;
    repeat (12) begin
      tick();
      if (out_valid) n++;
    end
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL rst_mid_stray_valid got=%0d want=0", n); end
    send(C1_KEY, C1_PT);
    wait_valid(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL rst_mid_relatency got=%0d want=10", n); end
    n_cmp++; if (out_text !== C1_CT) begin n_err++; $display("FAIL rst_mid_ct got=%h want=%h", out_text, C1_CT); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [0:127] k, p, exp;
    int           n, hold;
    for (int b = 0; b < 8; b++) begin
      k   = rand128();
      p   = rand128();
      exp = aes_ref(k, p);
      repeat ($urandom_range(0, 2)) tick();
      send(k, p);
      wait_valid(n);
      n_cmp++; if (n !== 10) begin n_err++; $display("FAIL rand%0d_latency got=%0d want=10", b, n); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        tick();
        n_cmp++; if ({out_valid, out_text} !== {1'b1, exp}) begin n_err++; $display("FAIL rand%0d_hold got=%b/%h want=1/%h", b, out_valid, out_text, exp); end
      end
      n_cmp++; if (out_text !== exp) begin n_err++; $display("FAIL rand%0d_ct got=%h want=%h key=%h pt=%h", b, out_text, exp, k, p); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if ({in_ready, out_valid, round} !== 6'b10_0000) begin n_err++; $display("FAIL rand%0d_drain got=%b want=%b", b, {in_ready, out_valid, round}, 6'b10_0000); end
    end
  endtask

`ifdef AES_SEQ_ABORT_EN
  task automatic test_abort();
    int n;
    send(C1_KEY, C1_PT);
    tick();
    tick();
    n_cmp++; if (round !== 4'd3) begin n_err++; $display("FAIL abort_run_round got=%0d want=3", round); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({in_ready, busy, out_valid, round} !== 7'b100_0000) begin n_err++; $display("FAIL abort_run_idle got=%b want=%b", {in_ready, busy, out_valid, round}, 7'b100_0000); end
    n_cmp++; if (out_text !== 128'h0) begin n_err++; $display("FAIL abort_run_cleared got=%h want=0", out_text); end
    n = 0;
    repeat (12) begin
      tick();
      if (out_valid) n++;
    end
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL abort_run_stray_valid got=%0d want=0", n); end
    // abort while idle must not block an accept
    abort    = 1'b1;
    in_key   = C1_KEY;
    in_text  = C1_PT;
    in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle_ready got=%b want=1", in_ready); end
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if ({busy, round} !== 5'b1_0001) begin n_err++; $display("FAIL abort_idle_accept got=%b want=%b", {busy, round}, 5'b1_0001); end
    wait_valid(n);
    n_cmp++; if (out_text !== C1_CT) begin n_err++; $display("FAIL abort_idle_ct got=%h want=%h", out_text, C1_CT); end
    // abort beats out_ready and a pending accept in DONE
    in_key    = B_KEY;
    in_text   = B_PT;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    abort     = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_done_ready got=%b want=0", in_ready); end
    tick();
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if ({in_ready, busy, out_valid, round} !== 7'b100_0000) begin n_err++; $display("FAIL abort_done_idle got=%b want=%b", {in_ready, busy, out_valid, round}, 7'b100_0000); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_text   = '0;
    in_key    = '0;
`ifdef AES_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
`ifdef AES_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
